dequant_expand: RTL

//  Inverse of the accumulator requantizer. Takes DN lanes of signed OW-bit activations
//  and expands each into a signed DW-bit accumulator-domain value:
//    out = sat_DW(((q - zp) * scale) <<< lsh)

---
 rtl/dequant_expand_pkg.sv | 23 ++
 rtl/dequant_expand_lane.sv | 28 ++
 rtl/dequant_expand.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dequant_expand_pkg.sv
// Shared widths, derived sizes and saturation bounds for the dequantizing expander.
package dequant_expand_pkg;
  localparam int DN   = 6;
  localparam int OW   = 8;
  localparam int MULW = 9;
  localparam int DW   = 22;
  localparam int LSHW = 3;
  localparam int CNTW = 16;

  localparam int DQW = OW + 1;
  localparam int PW  = DQW + MULW;
  localparam int SW  = PW + (1 << LSHW) - 1;

  localparam int SAT_HI = (1 << (DW - 1)) - 1;
  localparam int SAT_LO = -(1 << (DW - 1));
  localparam logic signed [SW-1:0] SAT_HI_S = SW'(SAT_HI);
  localparam logic signed [SW-1:0] SAT_LO_S = SW'(SAT_LO);

  typedef logic signed [DQW-1:0]  diff_t;
  typedef logic signed [MULW-1:0] scale_t;
  typedef logic signed [DW-1:0]   acc_t;
  typedef logic [LSHW-1:0]        lsh_t;
endpackage

// File: rtl/dequant_expand_lane.sv
// One lane of the expander: exact multiply, left shift, clamp to accumulator range.
module dequant_lane
  import dequant_expand_pkg::*;
(
  input  diff_t  d,
  input  scale_t scale,
  input  lsh_t   lsh,
  output acc_t   res
);

  function automatic acc_t sat_dw(input logic signed [SW-1:0] s);
    if (s > SAT_HI_S)
      return SAT_HI_S[DW-1:0];
    else if (s < SAT_LO_S)
      return SAT_LO_S[DW-1:0];
    else
      return s[DW-1:0];
  endfunction

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] shifted;

  // The shift width is sized so the worst-case product shifted by 7 cannot wrap.
  assign prod    = PW'(d) * PW'(scale);
  assign shifted = SW'(prod) <<< lsh;
  assign res     = sat_dw(shifted);

endmodule

// File: rtl/dequant_expand.sv
// Expands int8 activation lanes into saturated accumulator-domain values over a
// two-stage valid/ready pipeline with per-frame config latching and last/busy tracking.
module dequant_expand
  import dequant_expand_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [OW-1:0]   cfg_zp,
  input  logic [DN*MULW-1:0]     cfg_scale,
  input  logic [LSHW-1:0]        cfg_lsh,
  input  logic [CNTW-1:0]        cfg_frame_len,
  input  logic [DN*OW-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DN*DW-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  logic signed [OW-1:0] zp_q;
  logic [DN*MULW-1:0]   scale_q;
  logic [LSHW-1:0]      lsh_q;
  logic [CNTW-1:0]      len_q;
  logic [CNTW-1:0]      cnt;

  logic                 vld_p1, last_p1;
  logic [DN*DQW-1:0]    d_p1;
  logic [DN*MULW-1:0]   scl_p1;
  logic [LSHW-1:0]      lsh_p1;

  logic                 vld_p2, last_p2;
  logic [DN*DW-1:0]     res_p2;

  logic                 ld_p1, ld_p2, accept, first, is_last;
  logic signed [OW-1:0] zp_eff;
  logic [DN*MULW-1:0]   scale_eff;
  logic [LSHW-1:0]      lsh_eff;
  logic [CNTW-1:0]      len_eff, lim;
  logic [DN*DQW-1:0]    d_in;
  logic [DN*DW-1:0]     lane_res;

  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_p1    = !vld_p1 || ld_p2;
  assign in_ready = ld_p1;
  assign accept   = in_valid && in_ready;

  // The frame's first beat uses live cfg values, which are latched on that same beat.
  assign first     = (cnt == '0);
  assign zp_eff    = first ? cfg_zp        : zp_q;
  assign scale_eff = first ? cfg_scale     : scale_q;
  assign lsh_eff   = first ? cfg_lsh       : lsh_q;
  assign len_eff   = first ? cfg_frame_len : len_q;
  assign lim       = (len_eff == '0) ? '0 : len_eff - CNTW'(1);
  assign is_last   = (cnt == lim);

  for (genvar i = 0; i < DN; i++) begin : g_lane
    acc_t r;
    assign d_in[i*DQW +: DQW] = DQW'(signed'(in_data[i*OW +: OW])) - DQW'(zp_eff);
    dequant_lane u_lane (
      .d     (diff_t'(d_p1[i*DQW +: DQW])),
      .scale (scale_t'(scl_p1[i*MULW +: MULW])),
      .lsh   (lsh_p1),
      .res   (r)
    );
    assign lane_res[i*DW +: DW] = r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zp_q    <= '0;
      scale_q <= '0;
      lsh_q   <= '0;
      len_q   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      if (accept && first) begin
        zp_q    <= cfg_zp;
        scale_q <= cfg_scale;
        lsh_q   <= cfg_lsh;
        len_q   <= cfg_frame_len;
      end
      if (accept)
        cnt <= is_last ? '0 : cnt + CNTW'(1);
      if (accept && first)
        busy <= 1'b1;
      else if (out_valid && out_ready && out_last)
        busy <= 1'b0;
    end
  end

  // S1: zero-point removal; scale and shift travel with the beat so a new frame can
  // enter S1 while the previous frame's tail is still in S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      d_p1    <= '0;
      scl_p1  <= '0;
      lsh_p1  <= '0;
    end else if (ld_p1) begin
      vld_p1 <= accept;
      if (accept) begin
        d_p1    <= d_in;
        scl_p1  <= scale_eff;
        lsh_p1  <= lsh_eff;
        last_p1 <= is_last;
      end
    end
  end

  // S2: saturated accumulator-domain result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      res_p2  <= '0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2  <= lane_res;
        last_p2 <= last_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = vld_p2 && last_p2;
  assign out_data  = res_p2;

endmodule
